// File: rtl/cva6_dmem_responder.sv
// Data-memory responder model: a 4-deep count-only store drain FIFO and a
// single outstanding load. A small FSM services one transaction at a time and
// answers each one with a fixed-latency completion pulse.
module cva6_dmem_responder #(
    parameter int unsigned LOAD_LAT  = 2,  // 1..15
    parameter int unsigned STORE_LAT = 3   // 1..15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_req_i,
    input  logic       store_req_i,
    output logic       load_mem_resp_o,
    output logic       store_mem_resp_o,
    output logic       busy_o,
    output logic [2:0] store_pending_o,
    output logic       ovf_o
);

    typedef enum logic [1:0] {IDLE, LOAD_BUSY, STORE_BUSY} state_e;

    localparam logic [3:0] LOAD_INIT  = 4'(LOAD_LAT - 1);
    localparam logic [3:0] STORE_INIT = 4'(STORE_LAT - 1);
    localparam logic [2:0] STARV_MAX  = 3'd4;
    localparam logic [2:0] FIFO_DEPTH = 3'd4;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] starv_q, starv_d;
    logic [1:0] wptr_q, wptr_d;
    logic [1:0] rptr_q, rptr_d;
    logic [2:0] count_q, count_d;
    logic       load_pend_q, load_pend_d;
    logic       load_armed_q, load_armed_d;
    logic       ovf_q, ovf_d;

    logic       pop;
    logic       load_grant;
    logic       load_resp;
    logic       store_resp;

    // Grant / latency FSM. Decisions look only at registered FIFO count and
    // load_pend, so a request arriving on the same edge is never bypassed.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        starv_d    = starv_q;
        pop        = 1'b0;
        load_grant = 1'b0;
        load_resp  = 1'b0;
        store_resp = 1'b0;
        case (state_q)
            IDLE: begin
                // Stores win unless a load has already waited out 4 store grants.
                if (count_q != 3'd0 && !(load_pend_q && starv_q == STARV_MAX)) begin
                    state_d = STORE_BUSY;
                    pop     = 1'b1;
                    cnt_d   = STORE_INIT;
                    starv_d = load_pend_q ? starv_q + 3'd1 : 3'd0;
                end else if (load_pend_q) begin
                    state_d    = LOAD_BUSY;
                    load_grant = 1'b1;
                    cnt_d      = LOAD_INIT;
                    starv_d    = 3'd0;
                end
            end
            LOAD_BUSY: begin
                if (cnt_q == 4'd0) begin
                    load_resp = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STORE_BUSY: begin
                if (cnt_q == 4'd0) begin
                    store_resp = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Store FIFO bookkeeping; a push into a full FIFO with no pop is dropped.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (store_req_i && count_q == FIFO_DEPTH && !pop) begin
            ovf_d = 1'b1;
        end else begin
            if (store_req_i) wptr_d = wptr_q + 2'd1;
            if (pop)         rptr_d = rptr_q + 2'd1;
            count_d = count_q + 3'(store_req_i) - 3'(pop);
        end
    end

    // Load latch: one response per rising level of load_req_i.
    always_comb begin
        load_pend_d  = load_pend_q;
        load_armed_d = load_armed_q;
        if (load_grant)
            load_pend_d = 1'b0;
        else if (load_req_i && !load_pend_q && load_armed_q && state_q != LOAD_BUSY)
            load_pend_d = 1'b1;
        if (load_resp)   load_armed_d = 1'b0;
        if (!load_req_i) load_armed_d = 1'b1;
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            starv_q      <= 3'd0;
            wptr_q       <= 2'd0;
            rptr_q       <= 2'd0;
            count_q      <= 3'd0;
            load_pend_q  <= 1'b0;
            load_armed_q <= 1'b1;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            starv_q      <= starv_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            load_pend_q  <= load_pend_d;
            load_armed_q <= load_armed_d;
            ovf_q        <= ovf_d;
        end
    end

    assign load_mem_resp_o  = load_resp;
    assign store_mem_resp_o = store_resp;
    assign busy_o           = (state_q != IDLE);
    assign store_pending_o  = count_q;
    assign ovf_o            = ovf_q;

endmodule

// File: tb/tb_cva6_dmem_responder.sv
// Directed bench for cva6_dmem_responder at default latencies (load 2, store 3).
module tb_cva6_dmem_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_req = 1'b0;
    logic       store_req = 1'b0;
    logic       lresp, sresp, busy, ovf;
    logic [2:0] pending;

    int ncmp  = 0;
    int nfail = 0;

    cva6_dmem_responder dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .load_req_i       (load_req),
        .store_req_i      (store_req),
        .load_mem_resp_o  (lresp),
        .store_mem_resp_o (sresp),
        .busy_o           (busy),
        .store_pending_o  (pending),
        .ovf_o            (ovf)
    );

    always #5 clk = ~clk;

    // Advance past one rising edge; inputs set afterwards apply to the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int n_s, n_l, got;

        // Reset state
        tick(); tick();
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_lresp", 8'(lresp), 8'd0);
        chk("rst_sresp", 8'(sresp), 8'd0);
        chk("rst_pending", 8'(pending), 8'd0);
        chk("rst_ovf", 8'(ovf), 8'd0);
        rst = 1'b0;

        // Held load: single pulse in the cycle after E0+2
        load_req = 1'b1;
        tick();                                   // E0: load_pend set
        chk("ld_e0_busy", 8'(busy), 8'd0);
        tick();                                   // E1: grant
        chk("ld_e1_busy", 8'(busy), 8'd1);
        chk("ld_e1_lresp", 8'(lresp), 8'd0);
        tick();                                   // E2: counter reaches 0
        chk("ld_e2_lresp", 8'(lresp), 8'd1);
        chk("ld_e2_sresp", 8'(sresp), 8'd0);
        n_l = 0;
        for (int i = 0; i < 4; i++) begin         // E3..E6, request still held
            tick();
            n_l += int'(lresp);
        end
        chk("ld_hold_no_repeat", 8'(n_l), 8'd0);
        chk("ld_hold_idle", 8'(busy), 8'd0);
        load_req = 1'b0;
        tick();
        load_req = 1'b1;
        tick(); tick(); tick();
        chk("ld_rearm_lresp", 8'(lresp), 8'd1);
        tick();
        chk("ld_rearm_end", 8'(lresp), 8'd0);
        load_req = 1'b0;
        tick();

        // Single store: pending 1 then 0, pulse in the cycle after E0+3
        store_req = 1'b1;
        tick();                                   // E0: push
        store_req = 1'b0;
        chk("st_e0_pending", 8'(pending), 8'd1);
        chk("st_e0_busy", 8'(busy), 8'd0);
        tick();                                   // E1: grant + pop
        chk("st_e1_pending", 8'(pending), 8'd0);
        chk("st_e1_busy", 8'(busy), 8'd1);
        tick();                                   // E2
        chk("st_e2_sresp", 8'(sresp), 8'd0);
        tick();                                   // E3
        chk("st_e3_sresp", 8'(sresp), 8'd1);
        chk("st_e3_lresp", 8'(lresp), 8'd0);
        tick();                                   // E4
        chk("st_e4_sresp", 8'(sresp), 8'd0);
        chk("st_e4_busy", 8'(busy), 8'd0);

        // Store beats a same-edge load; one IDLE cycle separates the grants
        store_req = 1'b1;
        load_req  = 1'b1;
        tick();                                   // E0
        store_req = 1'b0;
        chk("pr_e0_pending", 8'(pending), 8'd1);
        tick();                                   // E1: store grant
        chk("pr_e1_busy", 8'(busy), 8'd1);
        chk("pr_e1_pending", 8'(pending), 8'd0);
        tick();                                   // E2
        chk("pr_e2_busy", 8'(busy), 8'd1);
        tick();                                   // E3
        chk("pr_e3_sresp", 8'(sresp), 8'd1);
        chk("pr_e3_lresp", 8'(lresp), 8'd0);
        tick();                                   // E4: IDLE gap
        chk("pr_e4_busy", 8'(busy), 8'd0);
        tick();                                   // E5: load grant
        chk("pr_e5_busy", 8'(busy), 8'd1);
        chk("pr_e5_lresp", 8'(lresp), 8'd0);
        tick();                                   // E6
        chk("pr_e6_lresp", 8'(lresp), 8'd1);
        chk("pr_e6_sresp", 8'(sresp), 8'd0);
        tick();                                   // E7
        chk("pr_e7_busy", 8'(busy), 8'd0);
        load_req = 1'b0;
        tick();

        // Overflow: store pulses on 6 consecutive edges starting with the load
        // grant. One entry drains at E4, so the 6th push finds the FIFO full.
        load_req = 1'b1;
        tick();                                   // E0: load_pend
        store_req = 1'b1;
        tick();                                   // E1: load grant, push
        chk("ov_e1_busy", 8'(busy), 8'd1);
        chk("ov_e1_pending", 8'(pending), 8'd1);
        tick();                                   // E2
        chk("ov_e2_pending", 8'(pending), 8'd2);
        chk("ov_e2_lresp", 8'(lresp), 8'd1);
        tick();                                   // E3
        chk("ov_e3_pending", 8'(pending), 8'd3);
        load_req = 1'b0;
        tick();                                   // E4: store grant, push+pop
        chk("ov_e4_pending", 8'(pending), 8'd3);
        tick();                                   // E5
        chk("ov_e5_pending", 8'(pending), 8'd4);
        chk("ov_e5_ovf", 8'(ovf), 8'd0);
        tick();                                   // E6: push dropped
        store_req = 1'b0;
        chk("ov_e6_pending", 8'(pending), 8'd4);
        chk("ov_e6_ovf", 8'(ovf), 8'd1);
        n_s = int'(sresp);
        n_l = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            n_s += int'(sresp);
            n_l += int'(lresp);
        end
        chk("ov_store_resps", 8'(n_s), 8'd5);
        chk("ov_no_load_resp", 8'(n_l), 8'd0);
        chk("ov_drained", 8'(pending), 8'd0);
        chk("ov_sticky", 8'(ovf), 8'd1);

        // Starvation cap: load served after exactly 4 store grants
        load_req = 1'b1;
        n_s = 0;
        got = 0;
        for (int i = 0; i < 60; i++) begin
            store_req = (i < 6);
            tick();
            n_s += int'(sresp);
            if (lresp) begin
                got = 1;
                break;
            end
        end
        store_req = 1'b0;
        chk("sv_load_served", 8'(got), 8'd1);
        chk("sv_stores_before", 8'(n_s), 8'd4);
        chk("sv_pending_at_load", 8'(pending), 8'd2);
        load_req = 1'b0;
        n_s = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_s += int'(sresp);
        end
        chk("sv_drain_resps", 8'(n_s), 8'd2);
        chk("sv_drain_pending", 8'(pending), 8'd0);
        chk("sv_drain_busy", 8'(busy), 8'd0);

        // Reset while LOAD_BUSY with counter=1
        load_req = 1'b1;
        tick();                                   // E0
        tick();                                   // E1: grant, counter 1
        chk("rm_pre_busy", 8'(busy), 8'd1);
        #2 rst = 1'b1;
        #1;
        chk("rm_async_busy", 8'(busy), 8'd0);
        chk("rm_async_lresp", 8'(lresp), 8'd0);
        chk("rm_async_pending", 8'(pending), 8'd0);
        chk("rm_async_ovf", 8'(ovf), 8'd0);
        tick();                                   // edge while in reset
        chk("rm_held_lresp", 8'(lresp), 8'd0);
        rst = 1'b0;
        tick();                                   // E0': fresh load_pend
        chk("rm_e0_busy", 8'(busy), 8'd0);
        chk("rm_e0_lresp", 8'(lresp), 8'd0);
        tick();                                   // E1'
        chk("rm_e1_busy", 8'(busy), 8'd1);
        tick();                                   // E2'
        chk("rm_e2_lresp", 8'(lresp), 8'd1);
        tick();                                   // E3'
        chk("rm_e3_lresp", 8'(lresp), 8'd0);
        load_req = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
